// File: rtl/branch_predictor_pkg.sv
// Shared encodings and defaults for the 2-bit bimodal branch predictor.
package branch_predictor_pkg;

    localparam int unsigned DEFAULT_ENTRIES = 64;
    localparam int unsigned DEFAULT_PC_W    = 32;

    // 2-bit saturating counter encodings
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Table initialisation / operating states
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Predicted direction carried by a counter value
    function automatic logic ctr_taken(input logic [1:0] cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup / execute update bus of the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned PC_W = branch_predictor_pkg::DEFAULT_PC_W
);
    logic            ready;
    logic            lk_valid;
    logic [PC_W-1:0] lk_pc;
    logic            pred_valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            up_valid;
    logic [PC_W-1:0] up_pc;
    logic            up_taken;
    logic [PC_W-1:0] up_target;

    modport master (
        input  ready, pred_valid, pred_taken, pred_target,
        output lk_valid, lk_pc, up_valid, up_pc, up_taken, up_target
    );

    modport slave (
        output ready, pred_valid, pred_taken, pred_target,
        input  lk_valid, lk_pc, up_valid, up_pc, up_taken, up_target
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-value logic of a 2-bit saturating counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_nxt_c_o
);

    // Count towards the resolved direction, holding at either end
    always_comb begin
        cnt_nxt_c_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != CTR_ST) cnt_nxt_c_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != CTR_SNT) cnt_nxt_c_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of 2-bit counters indexed by pc[log2(ENTRIES)+1:2],
// swept to weak-not-taken after reset, 1-cycle lookup with update bypass.
// Optional BTB (valid/tag/target per entry) enabled by BRANCH_PREDICTOR_BTB_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = DEFAULT_ENTRIES,
    parameter int unsigned PC_W    = DEFAULT_PC_W
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    state_e            state_q;
    logic [IDX_W-1:0]  sweep_q;
    logic              ready_q;
    logic              pred_valid_q;
    logic              pred_taken_q;
    logic [PC_W-1:0]   pred_target_q;

    logic [1:0]        cnt_q [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  up_idx;
    logic              lk_fire;
    logic              up_fire;
    logic              same_idx;
    logic [1:0]        up_cnt;
    logic [1:0]        up_cnt_nxt;
    logic [1:0]        lk_cnt;
    logic              lk_taken_c;
    logic [PC_W-1:0]   lk_target_c;

    assign lk_idx   = bp.lk_pc[IDX_W+1:2];
    assign up_idx   = bp.up_pc[IDX_W+1:2];
    assign lk_fire  = bp.lk_valid & ready_q;
    assign up_fire  = bp.up_valid & ready_q;
    assign same_idx = (lk_idx == up_idx);

    assign up_cnt = cnt_q[up_idx];

    sat_counter2 u_sat (
        .cnt_i       (up_cnt),
        .taken_i     (bp.up_taken),
        .cnt_nxt_c_o (up_cnt_nxt)
    );

    // Lookup sees the post-update counter when both hit the same entry
    assign lk_cnt = (up_fire && same_idx) ? up_cnt_nxt : cnt_q[lk_idx];

`ifdef BRANCH_PREDICTOR_BTB_EN
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic              btb_v_q   [ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q [ENTRIES];
    logic [PC_W-1:0]   btb_tgt_q [ENTRIES];

    logic              btb_wr;
    logic              btb_byp;
    logic [TAG_W-1:0]  lk_tag;
    logic [TAG_W-1:0]  up_tag;
    logic              lk_v;
    logic [TAG_W-1:0]  lk_tag_st;
    logic              unused_pc_lsb;

    assign lk_tag  = bp.lk_pc[PC_W-1:IDX_W+2];
    assign up_tag  = bp.up_pc[PC_W-1:IDX_W+2];
    assign btb_wr  = up_fire & bp.up_taken;
    assign btb_byp = btb_wr & same_idx;

    assign lk_v        = btb_byp ? 1'b1      : btb_v_q[lk_idx];
    assign lk_tag_st   = btb_byp ? up_tag    : btb_tag_q[lk_idx];
    assign lk_target_c = btb_byp ? bp.up_target : btb_tgt_q[lk_idx];
    assign lk_taken_c  = ctr_taken(lk_cnt) & lk_v & (lk_tag_st == lk_tag);

    assign unused_pc_lsb = ^{bp.lk_pc[1:0], bp.up_pc[1:0]};

    // BTB storage: cleared by the sweep, written by taken updates
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                btb_v_q[sweep_q]   <= 1'b0;
                btb_tag_q[sweep_q] <= '0;
                btb_tgt_q[sweep_q] <= '0;
            end else if (btb_wr) begin
                btb_v_q[up_idx]   <= 1'b1;
                btb_tag_q[up_idx] <= up_tag;
                btb_tgt_q[up_idx] <= bp.up_target;
            end
        end
    end
`else
    logic unused_pc;

    assign lk_taken_c  = ctr_taken(lk_cnt);
    assign lk_target_c = '0;
    assign unused_pc   = ^{bp.lk_pc[1:0], bp.up_pc[1:0],
                           bp.lk_pc[PC_W-1:IDX_W+2], bp.up_pc[PC_W-1:IDX_W+2],
                           bp.up_target};
`endif

    // Counter table: sweep writes weak-not-taken, then resolved updates
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                cnt_q[sweep_q] <= CTR_WNT;
            end else if (up_fire) begin
                cnt_q[up_idx] <= up_cnt_nxt;
            end
        end
    end

    // INIT/RUN control and registered prediction outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            sweep_q       <= '0;
            ready_q       <= 1'b0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            if (state_q == ST_INIT) begin
                sweep_q <= sweep_q + IDX_W'(1);
                if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
            end
            pred_valid_q  <= lk_fire;
            pred_taken_q  <= lk_fire & lk_taken_c;
            pred_target_q <= lk_fire ? lk_target_c : '0;
        end
    end

    assign bp.ready       = ready_q;
    assign bp.pred_valid  = pred_valid_q;
    assign bp.pred_taken  = pred_taken_q;
    assign bp.pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// reset/sweep sequences and randomized traffic against a behavioural model.
// Build with BRANCH_PREDICTOR_BTB_EN defined to cover the BTB variant.
module tb_branch_predictor;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned PC_W    = 32;
`ifdef BRANCH_PREDICTOR_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(PC_W)) bp_if ();

    branch_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integer counters plus optional BTB arrays
    int          m_cnt [ENTRIES];
    bit          m_v   [ENTRIES];
    logic [31:0] m_tag [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_cnt[i] = 1;
            m_v[i]   = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
    endtask

    task automatic model_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        int i;
        i = idx_of(pc);
        if (taken) begin
            if (m_cnt[i] < 3) m_cnt[i] = m_cnt[i] + 1;
            m_v[i]   = 1'b1;
            m_tag[i] = tag_of(pc);
            m_tgt[i] = tgt;
        end else begin
            if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
        int i;
        i = idx_of(pc);
        if (BTB) begin
            taken = (m_cnt[i] >= 2) && m_v[i] && (m_tag[i] == tag_of(pc));
            tgt   = m_tgt[i];
        end else begin
            taken = (m_cnt[i] >= 2);
            tgt   = '0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bp_if.lk_valid  = 1'b0;
        bp_if.lk_pc     = '0;
        bp_if.up_valid  = 1'b0;
        bp_if.up_pc     = '0;
        bp_if.up_taken  = 1'b0;
        bp_if.up_target = '0;
    endtask

    // Apply one cycle of traffic and compare the registered response
    task automatic drive(input string name,
                         input logic lkv, input logic [31:0] lkpc,
                         input logic upv, input logic [31:0] uppc,
                         input logic upt, input logic [31:0] uptgt,
                         input logic exp_t, input logic [31:0] exp_tgt);
        bp_if.lk_valid  = lkv;
        bp_if.lk_pc     = lkpc;
        bp_if.up_valid  = upv;
        bp_if.up_pc     = uppc;
        bp_if.up_taken  = upt;
        bp_if.up_target = uptgt;
        cyc();
        idle_inputs();
        check({name, ".valid"}, 32'(bp_if.pred_valid), 32'(lkv));
        if (lkv) begin
            check({name, ".taken"}, 32'(bp_if.pred_taken), 32'(exp_t));
            check({name, ".target"}, bp_if.pred_target, exp_tgt);
        end
    endtask

    // Count cycles from reset release until ready, bounded
    task automatic wait_ready(input string name, output int n);
        n = 0;
        while (bp_if.ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        check(name, 32'(n), 32'(ENTRIES));
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = ($urandom_range(3, 0) << 8) | ($urandom_range(7, 0) << 2) | $urandom_range(3, 0);
        return p;
    endfunction

    typedef struct {
        logic        lkv;
        logic [31:0] lkpc;
        logic        upv;
        logic [31:0] uppc;
        logic        upt;
        logic [31:0] uptgt;
        logic        exp_t;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic lkv, input logic [31:0] lkpc,
                                input logic upv, input logic [31:0] uppc,
                                input logic upt, input logic [31:0] uptgt,
                                input logic exp_t, input logic [31:0] btb_tgt);
        vec_t v;
        v.lkv     = lkv;
        v.lkpc    = lkpc;
        v.upv     = upv;
        v.uppc    = uppc;
        v.upt     = upt;
        v.uptgt   = uptgt;
        v.exp_t   = exp_t;
        v.exp_tgt = BTB ? btb_tgt : 32'h0;
        return v;
    endfunction

    initial begin
        int          n;
        bit          leaked;
        logic        e_t;
        logic [31:0] e_tgt;
        logic        lkv, upv, upt;
        logic [31:0] lkpc, uppc, uptgt;

        // Note: 0x100, 0x200 and 0x1100 share table index 0 with different tags
        vecs[0]  = mk(0, 32'h000, 1, 32'h100, 1, 32'h800, 0, 32'h000);
        vecs[1]  = mk(0, 32'h000, 1, 32'h100, 1, 32'h800, 0, 32'h000);
        vecs[2]  = mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 32'h800);
        vecs[3]  = mk(0, 32'h000, 1, 32'h100, 1, 32'h800, 0, 32'h000);
        vecs[4]  = mk(1, 32'h100, 1, 32'h100, 1, 32'h800, 1, 32'h800);
        vecs[5]  = mk(1, 32'h100, 1, 32'h100, 0, 32'h000, 1, 32'h800);
        vecs[6]  = mk(1, 32'h100, 1, 32'h100, 0, 32'h000, 0, 32'h800);
        vecs[7]  = mk(0, 32'h000, 1, 32'h200, 0, 32'h000, 0, 32'h000);
        vecs[8]  = mk(0, 32'h000, 1, 32'h200, 0, 32'h000, 0, 32'h000);
        vecs[9]  = mk(1, 32'h200, 1, 32'h200, 0, 32'h000, 0, 32'h800);
        vecs[10] = mk(1, 32'h200, 1, 32'h200, 1, 32'h900, 0, 32'h900);
        vecs[11] = mk(1, 32'h200, 0, 32'h000, 0, 32'h000, 0, 32'h900);
        vecs[12] = mk(1, 32'h040, 1, 32'h040, 1, 32'hA00, 1, 32'hA00);
        vecs[13] = mk(1, 32'h040, 0, 32'h000, 0, 32'h000, 1, 32'hA00);
        vecs[14] = mk(1, 32'h040, 1, 32'h044, 1, 32'hB00, 1, 32'hA00);
        vecs[15] = mk(1, 32'h044, 0, 32'h000, 0, 32'h000, 1, 32'hB00);

        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();

        // Reset state
        check("rst.ready", 32'(bp_if.ready), 32'h0);
        check("rst.pred_valid", 32'(bp_if.pred_valid), 32'h0);
        check("rst.pred_taken", 32'(bp_if.pred_taken), 32'h0);
        check("rst.pred_target", bp_if.pred_target, 32'h0);

        // Sweep with traffic that must be ignored while not ready
        n = 0;
        leaked = 1'b0;
        while (bp_if.ready !== 1'b1 && n < 200) begin
            bp_if.lk_valid = 1'b1;
            bp_if.lk_pc    = rand_pc();
            bp_if.up_valid = 1'b1;
            bp_if.up_pc    = rand_pc();
            bp_if.up_taken = 1'b1;
            bp_if.up_target = 32'hDEAD0000;
            cyc();
            if (bp_if.pred_valid !== 1'b0 || bp_if.pred_taken !== 1'b0 || bp_if.pred_target !== '0)
                leaked = 1'b1;
            n++;
        end
        idle_inputs();
        check("init.ready_latency", 32'(n), 32'(ENTRIES));
        check("init.outputs_quiet", 32'(leaked), 32'h0);

        // First lookup after init predicts not-taken
        drive("first_lookup", 1, 32'h0000_1234, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        cyc();
        check("idle.pred_valid", 32'(bp_if.pred_valid), 32'h0);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].upv) model_update(vecs[i].uppc, vecs[i].upt, vecs[i].uptgt);
            drive($sformatf("vec%0d", i), vecs[i].lkv, vecs[i].lkpc, vecs[i].upv,
                  vecs[i].uppc, vecs[i].upt, vecs[i].uptgt, vecs[i].exp_t, vecs[i].exp_tgt);
        end

        // Tag check: same index, different tag
        model_update(32'h100, 1'b1, 32'h800);
        drive("tag.up0", 0, 32'h0, 1, 32'h100, 1, 32'h800, 0, 32'h0);
        model_update(32'h100, 1'b1, 32'h800);
        drive("tag.up1", 0, 32'h0, 1, 32'h100, 1, 32'h800, 0, 32'h0);
        drive("tag.hit", 1, 32'h100, 0, 32'h0, 0, 32'h0, 1'b1, BTB ? 32'h800 : 32'h0);
        drive("tag.miss", 1, 32'h1100, 0, 32'h0, 0, 32'h0, BTB ? 1'b0 : 1'b1, BTB ? 32'h800 : 32'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            lkv   = 1'($urandom_range(1, 0));
            upv   = 1'($urandom_range(1, 0));
            lkpc  = rand_pc();
            uppc  = ($urandom_range(3, 0) == 0) ? lkpc : rand_pc();
            upt   = 1'($urandom_range(1, 0));
            uptgt = $urandom() & 32'hFFFF_FFFC;
            if (upv) model_update(uppc, upt, uptgt);
            model_predict(lkpc, e_t, e_tgt);
            drive($sformatf("rnd%0d", k), lkv, lkpc, upv, uppc, upt, uptgt, e_t, e_tgt);
        end

        // Reset during RUN drops a same-cycle lookup
        bp_if.lk_valid = 1'b1;
        bp_if.lk_pc    = 32'h040;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        check("run_rst.pred_valid", 32'(bp_if.pred_valid), 32'h0);
        check("run_rst.ready", 32'(bp_if.ready), 32'h0);

        // Reset again at sweep index 20; the sweep must restart
        repeat (20) cyc();
        check("mid_sweep.ready", 32'(bp_if.ready), 32'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_ready("mid_sweep.ready_latency", n);

        // Previously trained entries are back to weak-not-taken
        drive("post_rst.0x40", 1, 32'h040, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive("post_rst.0x100", 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
